// File: rtl/mcu_arb_pkg.sv
// Shared widths, owner/state encodings and the tie-break helper for mcu_request_arbiter.
package mcu_arb_pkg;

   localparam int ADDR_W = 26;
   localparam int DATA_W = 32;
   localparam int MASK_W = 4;

   localparam logic OWNER_A = 1'b0;
   localparam logic OWNER_B = 1'b1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   // Single requester wins outright; on a tie the client that did not win last time wins.
   function automatic logic pick_winner(input logic a_req, input logic b_req,
                                        input logic last_grant);
      if (a_req && b_req) begin
         return ~last_grant;
      end else if (a_req) begin
         return OWNER_A;
      end else begin
         return OWNER_B;
      end
   endfunction

endpackage

// File: rtl/read_tag_pipe.sv
// Shift register of {valid, tag} that tracks which client owns each in-flight read.
module read_tag_pipe #(
   parameter int unsigned DEPTH = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic push,
   input  logic push_tag,
   output logic out_valid,
   output logic out_tag
);

   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_tag;

   // Stage 0 loads on a read ack (invalid otherwise); every stage shifts each cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_valid <= '0;
         r_tag   <= '0;
      end else begin
         r_valid[0] <= push;
         r_tag[0]   <= push_tag;
         for (int i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_tag[i]   <= r_tag[i-1];
         end
      end
   end

   assign out_valid = r_valid[DEPTH-1];
   assign out_tag   = r_tag[DEPTH-1];

endmodule

// File: rtl/mcu_request_arbiter.sv
// Two-client round-robin front end for the DDR controller's user_req handshake.
module mcu_request_arbiter
   import mcu_arb_pkg::*;
#(
   parameter int unsigned READ_LATENCY = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              A_REQ,
   input  logic              A_WE,
   input  logic [MASK_W-1:0] A_WE_ARRAY,
   input  logic [ADDR_W-1:0] A_ADDRESS,
   input  logic [DATA_W-1:0] A_DATAIN,
   output logic              A_ACK,
   output logic              A_DATA_VALID,
   output logic [DATA_W-1:0] A_DATAOUT,
   input  logic              B_REQ,
   input  logic              B_WE,
   input  logic [MASK_W-1:0] B_WE_ARRAY,
   input  logic [ADDR_W-1:0] B_ADDRESS,
   input  logic [DATA_W-1:0] B_DATAIN,
   output logic              B_ACK,
   output logic              B_DATA_VALID,
   output logic [DATA_W-1:0] B_DATAOUT,
   output logic              USER_REQ,
   output logic              USER_REQ_WE,
   output logic [MASK_W-1:0] USER_REQ_WE_ARRAY,
   output logic [ADDR_W-1:0] USER_REQ_ADDRESS,
   output logic [DATA_W-1:0] USER_REQ_DATAIN,
   input  logic              USER_REQ_ACK,
   input  logic [DATA_W-1:0] USER_REQ_DATAOUT
);

   state_t            r_state, w_state_next;
   logic              r_owner, w_owner_next;
   logic              r_last_grant, w_last_grant_next;
   logic              r_req, w_req_next;
   logic              r_we, w_we_next;
   logic [MASK_W-1:0] r_we_array, w_we_array_next;
   logic [ADDR_W-1:0] r_addr, w_addr_next;
   logic [DATA_W-1:0] r_datain, w_datain_next;

   logic              w_winner;
   logic              w_ack;
   logic              w_push;
   logic              w_out_valid;
   logic              w_out_tag;

   assign w_winner = pick_winner(A_REQ, B_REQ, r_last_grant);

   // State and request registers; reset drops any pending request immediately.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state      <= ST_IDLE;
         r_owner      <= OWNER_A;
         r_last_grant <= OWNER_B;
         r_req        <= 1'b0;
         r_we         <= 1'b0;
         r_we_array   <= '0;
         r_addr       <= '0;
         r_datain     <= '0;
      end else begin
         r_state      <= w_state_next;
         r_owner      <= w_owner_next;
         r_last_grant <= w_last_grant_next;
         r_req        <= w_req_next;
         r_we         <= w_we_next;
         r_we_array   <= w_we_array_next;
         r_addr       <= w_addr_next;
         r_datain     <= w_datain_next;
      end
   end

   // Next-state: latch the winner's fields in IDLE, hold them stable until the controller acks.
   always_comb begin
      w_state_next      = r_state;
      w_owner_next      = r_owner;
      w_last_grant_next = r_last_grant;
      w_req_next        = r_req;
      w_we_next         = r_we;
      w_we_array_next   = r_we_array;
      w_addr_next       = r_addr;
      w_datain_next     = r_datain;
      w_ack             = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (A_REQ || B_REQ) begin
               w_owner_next    = w_winner;
               w_we_next       = (w_winner == OWNER_A) ? A_WE       : B_WE;
               w_we_array_next = (w_winner == OWNER_A) ? A_WE_ARRAY : B_WE_ARRAY;
               w_addr_next     = (w_winner == OWNER_A) ? A_ADDRESS  : B_ADDRESS;
               w_datain_next   = (w_winner == OWNER_A) ? A_DATAIN   : B_DATAIN;
               w_req_next      = 1'b1;
               w_state_next    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (USER_REQ_ACK) begin
               w_ack             = 1'b1;
               w_last_grant_next = r_owner;
               w_req_next        = 1'b0;
               w_state_next      = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign w_push = w_ack & ~r_we;

   read_tag_pipe #(
      .DEPTH(READ_LATENCY)
   ) u_tag_pipe (
      .CLK      (CLK),
      .RST      (RST),
      .push     (w_push),
      .push_tag (r_owner),
      .out_valid(w_out_valid),
      .out_tag  (w_out_tag)
   );

   assign A_ACK        = w_ack & (r_owner == OWNER_A);
   assign B_ACK        = w_ack & (r_owner == OWNER_B);
   assign A_DATA_VALID = w_out_valid & (w_out_tag == OWNER_A);
   assign B_DATA_VALID = w_out_valid & (w_out_tag == OWNER_B);
   // Both clients see the raw read bus; each qualifies it with its own valid.
   assign A_DATAOUT    = USER_REQ_DATAOUT;
   assign B_DATAOUT    = USER_REQ_DATAOUT;

   assign USER_REQ          = r_req;
   assign USER_REQ_WE       = r_we;
   assign USER_REQ_WE_ARRAY = r_we_array;
   assign USER_REQ_ADDRESS  = r_addr;
   assign USER_REQ_DATAIN   = r_datain;

endmodule

// File: tb/tb_mcu_request_arbiter.sv
// Self-checking bench for mcu_request_arbiter: scripted tasks plus a read-valid scoreboard.
module tb_mcu_request_arbiter;

   localparam int LAT = 4;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        A_REQ = 1'b0, A_WE = 1'b0;
   logic [3:0]  A_WE_ARRAY = '0;
   logic [25:0] A_ADDRESS = '0;
   logic [31:0] A_DATAIN = '0;
   logic        A_ACK, A_DATA_VALID;
   logic [31:0] A_DATAOUT;
   logic        B_REQ = 1'b0, B_WE = 1'b0;
   logic [3:0]  B_WE_ARRAY = '0;
   logic [25:0] B_ADDRESS = '0;
   logic [31:0] B_DATAIN = '0;
   logic        B_ACK, B_DATA_VALID;
   logic [31:0] B_DATAOUT;
   logic        USER_REQ, USER_REQ_WE;
   logic [3:0]  USER_REQ_WE_ARRAY;
   logic [25:0] USER_REQ_ADDRESS;
   logic [31:0] USER_REQ_DATAIN;
   logic        USER_REQ_ACK = 1'b0;
   logic [31:0] USER_REQ_DATAOUT;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   logic use_fixed = 1'b0;

   typedef struct {
      int          cycle;
      logic        client;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   mcu_request_arbiter #(.READ_LATENCY(LAT)) dut (
      .CLK(CLK), .RST(RST),
      .A_REQ(A_REQ), .A_WE(A_WE), .A_WE_ARRAY(A_WE_ARRAY), .A_ADDRESS(A_ADDRESS),
      .A_DATAIN(A_DATAIN), .A_ACK(A_ACK), .A_DATA_VALID(A_DATA_VALID), .A_DATAOUT(A_DATAOUT),
      .B_REQ(B_REQ), .B_WE(B_WE), .B_WE_ARRAY(B_WE_ARRAY), .B_ADDRESS(B_ADDRESS),
      .B_DATAIN(B_DATAIN), .B_ACK(B_ACK), .B_DATA_VALID(B_DATA_VALID), .B_DATAOUT(B_DATAOUT),
      .USER_REQ(USER_REQ), .USER_REQ_WE(USER_REQ_WE), .USER_REQ_WE_ARRAY(USER_REQ_WE_ARRAY),
      .USER_REQ_ADDRESS(USER_REQ_ADDRESS), .USER_REQ_DATAIN(USER_REQ_DATAIN),
      .USER_REQ_ACK(USER_REQ_ACK), .USER_REQ_DATAOUT(USER_REQ_DATAOUT)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   assign USER_REQ_DATAOUT = use_fixed ? 32'hDEADBEEF : {16'hD0D0, cyc[15:0]};

   function automatic logic [31:0] exp_data(input int c);
      return use_fixed ? 32'hDEADBEEF : {16'hD0D0, c[15:0]};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic mid();
      @(negedge CLK);
   endtask

   task automatic push_read(input logic client);
      exp_q.push_back('{cycle: cyc + LAT, client: client, data: exp_data(cyc + LAT)});
   endtask

   // Scoreboard: every valid strobe must match the oldest expected read, on time.
   always @(negedge CLK) begin
      if (!RST) begin
         while (exp_q.size() > 0 && exp_q[0].cycle < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_valid: cycle %0d got no strobe, want client %0d",
                     exp_q[0].cycle, exp_q[0].client);
            void'(exp_q.pop_front());
         end
         if (A_DATA_VALID || B_DATA_VALID) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid: cycle %0d got A=%0b B=%0b, want none",
                        cyc, A_DATA_VALID, B_DATA_VALID);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.cycle !== cyc || A_DATA_VALID !== (mon_e.client == 1'b0) ||
                   B_DATA_VALID !== (mon_e.client == 1'b1) ||
                   (mon_e.client ? B_DATAOUT : A_DATAOUT) !== mon_e.data) begin
                  errors++;
                  $display("FAIL valid_route: got cyc=%0d A=%0b B=%0b data=%h, want cyc=%0d client=%0d data=%h",
                           cyc, A_DATA_VALID, B_DATA_VALID,
                           mon_e.client ? B_DATAOUT : A_DATAOUT,
                           mon_e.cycle, mon_e.client, mon_e.data);
               end
            end
         end
      end
   end

   task automatic test_reset();
      RST = 1'b1;
      A_REQ = 1'b1;
      USER_REQ_ACK = 1'b1;
      tick();
      tick();
      mid();
      checks++;
      if ({USER_REQ, USER_REQ_WE, USER_REQ_WE_ARRAY, USER_REQ_ADDRESS, USER_REQ_DATAIN} !== '0) begin
         errors++;
         $display("FAIL reset_fields: got req=%0b we=%0b mask=%h addr=%h data=%h, want all 0",
                  USER_REQ, USER_REQ_WE, USER_REQ_WE_ARRAY, USER_REQ_ADDRESS, USER_REQ_DATAIN);
      end
      checks++;
      if ({A_ACK, B_ACK, A_DATA_VALID, B_DATA_VALID} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_strobes: got ack=%0b%0b valid=%0b%0b, want 0000",
                  A_ACK, B_ACK, A_DATA_VALID, B_DATA_VALID);
      end
      tick();
      RST = 1'b0;
      A_REQ = 1'b0;
      USER_REQ_ACK = 1'b0;
   endtask

   task automatic test_single_read();
      use_fixed = 1'b1;
      tick();
      A_REQ = 1'b1; A_WE = 1'b0; A_WE_ARRAY = 4'hF;
      A_ADDRESS = 26'h0000123; A_DATAIN = 32'h11111111;
      mid();
      checks++;
      if (USER_REQ !== 1'b0) begin
         errors++;
         $display("FAIL sr_req_early: got %0b want 0", USER_REQ);
      end
      tick();
      mid();
      checks++;
      if (USER_REQ !== 1'b1 || USER_REQ_ADDRESS !== 26'h0000123 || USER_REQ_WE !== 1'b0) begin
         errors++;
         $display("FAIL sr_issue: got req=%0b addr=%h we=%0b want 1 0000123 0",
                  USER_REQ, USER_REQ_ADDRESS, USER_REQ_WE);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         mid();
         checks++;
         if (A_ACK !== 1'b0 || USER_REQ !== 1'b1) begin
            errors++;
            $display("FAIL sr_hold: got ack=%0b req=%0b want 0 1", A_ACK, USER_REQ);
         end
      end
      tick();
      USER_REQ_ACK = 1'b1;
      push_read(1'b0);
      mid();
      checks++;
      if (A_ACK !== 1'b1 || B_ACK !== 1'b0) begin
         errors++;
         $display("FAIL sr_ack: got A=%0b B=%0b want 1 0", A_ACK, B_ACK);
      end
      tick();
      USER_REQ_ACK = 1'b0;
      A_REQ = 1'b0;
      mid();
      checks++;
      if (USER_REQ !== 1'b0 || A_ACK !== 1'b0) begin
         errors++;
         $display("FAIL sr_release: got req=%0b ack=%0b want 0 0", USER_REQ, A_ACK);
      end
      repeat (LAT + 2) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sr_drain: got %0d pending want 0", exp_q.size());
      end
      use_fixed = 1'b0;
   endtask

   task automatic test_round_robin();
      logic exp_b;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      tick();
      A_REQ = 1'b1; A_WE = 1'b0; A_ADDRESS = 26'h0000A0A;
      B_REQ = 1'b1; B_WE = 1'b0; B_ADDRESS = 26'h0000B0B;
      mid();
      for (int g = 0; g < 4; g++) begin
         exp_b = (g % 2) == 1;
         tick();
         checks++;
         if (USER_REQ !== 1'b1 ||
             USER_REQ_ADDRESS !== (exp_b ? 26'h0000B0B : 26'h0000A0A)) begin
            errors++;
            $display("FAIL rr_grant%0d: got req=%0b addr=%h want 1 %s",
                     g, USER_REQ, USER_REQ_ADDRESS, exp_b ? "0000b0b" : "0000a0a");
         end
         USER_REQ_ACK = 1'b1;
         push_read(exp_b);
         mid();
         checks++;
         if (A_ACK !== !exp_b || B_ACK !== exp_b) begin
            errors++;
            $display("FAIL rr_ack%0d: got A=%0b B=%0b want %0b %0b", g, A_ACK, B_ACK, !exp_b, exp_b);
         end
         tick();
         USER_REQ_ACK = 1'b0;
         if (g == 3) begin
            A_REQ = 1'b0;
            B_REQ = 1'b0;
         end
         mid();
         checks++;
         if (USER_REQ !== 1'b0) begin
            errors++;
            $display("FAIL rr_bubble%0d: got req=%0b want 0", g, USER_REQ);
         end
      end
      repeat (LAT + 2) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rr_drain: got %0d pending want 0", exp_q.size());
      end
   endtask

   task automatic test_write_b();
      tick();
      B_REQ = 1'b1; B_WE = 1'b1; B_WE_ARRAY = 4'b0101;
      B_ADDRESS = 26'h1FFFFFF; B_DATAIN = 32'hCAFEF00D;
      mid();
      for (int i = 0; i < 2; i++) begin
         tick();
         if (i == 1) begin
            B_WE_ARRAY = 4'b0000; B_ADDRESS = '0; B_DATAIN = '0;
         end
         mid();
         checks++;
         if ({USER_REQ, USER_REQ_WE, USER_REQ_WE_ARRAY, USER_REQ_ADDRESS, USER_REQ_DATAIN} !==
             {1'b1, 1'b1, 4'b0101, 26'h1FFFFFF, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL wr_fields%0d: got req=%0b we=%0b mask=%b addr=%h data=%h want 1 1 0101 1ffffff cafef00d",
                     i, USER_REQ, USER_REQ_WE, USER_REQ_WE_ARRAY, USER_REQ_ADDRESS, USER_REQ_DATAIN);
         end
      end
      tick();
      USER_REQ_ACK = 1'b1;
      mid();
      checks++;
      if (B_ACK !== 1'b1 || A_ACK !== 1'b0) begin
         errors++;
         $display("FAIL wr_ack: got A=%0b B=%0b want 0 1", A_ACK, B_ACK);
      end
      tick();
      USER_REQ_ACK = 1'b0;
      B_REQ = 1'b0;
      B_WE = 1'b0;
      mid();
      checks++;
      if (USER_REQ !== 1'b0) begin
         errors++;
         $display("FAIL wr_release: got req=%0b want 0", USER_REQ);
      end
      repeat (LAT + 3) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL wr_drain: got %0d pending want 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      // last_grant is B after the write test, so A wins the first tie here.
      tick();
      A_REQ = 1'b1; A_WE = 1'b0; A_ADDRESS = 26'h0000A0A;
      B_REQ = 1'b1; B_WE = 1'b0; B_ADDRESS = 26'h0000B0B;
      tick();
      USER_REQ_ACK = 1'b1;
      push_read(1'b0);
      tick();
      USER_REQ_ACK = 1'b0;
      tick();
      USER_REQ_ACK = 1'b1;
      push_read(1'b1);
      tick();
      USER_REQ_ACK = 1'b0;
      tick();
      RST = 1'b1;
      #1;
      checks++;
      if (USER_REQ !== 1'b0 || A_ACK !== 1'b0 || B_ACK !== 1'b0) begin
         errors++;
         $display("FAIL rm_async_drop: got req=%0b ack=%0b%0b want 0 00", USER_REQ, A_ACK, B_ACK);
      end
      exp_q.delete();
      repeat (3) tick();
      RST = 1'b0;
      mid();
      checks++;
      if (USER_REQ !== 1'b0) begin
         errors++;
         $display("FAIL rm_idle_after: got req=%0b want 0", USER_REQ);
      end
      tick();
      USER_REQ_ACK = 1'b1;
      push_read(1'b0);
      mid();
      checks++;
      if (USER_REQ !== 1'b1 || USER_REQ_ADDRESS !== 26'h0000A0A || A_ACK !== 1'b1) begin
         errors++;
         $display("FAIL rm_first_tie: got req=%0b addr=%h A_ACK=%0b want 1 0000a0a 1",
                  USER_REQ, USER_REQ_ADDRESS, A_ACK);
      end
      tick();
      USER_REQ_ACK = 1'b0;
      A_REQ = 1'b0;
      B_REQ = 1'b0;
      repeat (LAT + 6) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rm_drain: got %0d pending want 0", exp_q.size());
      end
   endtask

   task automatic test_idle_ack();
      for (int i = 0; i < 3; i++) begin
         tick();
         USER_REQ_ACK = 1'b1;
         mid();
         checks++;
         if (A_ACK !== 1'b0 || B_ACK !== 1'b0 || USER_REQ !== 1'b0) begin
            errors++;
            $display("FAIL ia_ignored%0d: got ack=%0b%0b req=%0b want 00 0", i, A_ACK, B_ACK, USER_REQ);
         end
      end
      tick();
      USER_REQ_ACK = 1'b0;
      A_REQ = 1'b1; A_WE = 1'b0; A_ADDRESS = 26'h0000003;
      tick();
      mid();
      checks++;
      if (USER_REQ !== 1'b1 || USER_REQ_ADDRESS !== 26'h0000003) begin
         errors++;
         $display("FAIL ia_still_idle: got req=%0b addr=%h want 1 0000003", USER_REQ, USER_REQ_ADDRESS);
      end
      tick();
      USER_REQ_ACK = 1'b1;
      push_read(1'b0);
      mid();
      checks++;
      if (A_ACK !== 1'b1) begin
         errors++;
         $display("FAIL ia_ack: got %0b want 1", A_ACK);
      end
      tick();
      USER_REQ_ACK = 1'b0;
      A_REQ = 1'b0;
      repeat (LAT + 2) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL ia_drain: got %0d pending want 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_b();
      test_reset_mid();
      test_idle_ack();
      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mcu_request_arbiter.md
# mcu_request_arbiter

Two-client front end for `ddr_memory_controler`. It accepts single-word requests from clients A and B and arbitrates between them round-robin. It drives the controller's `user_req_*` handshake and holds each request until the controller acknowledges it. It tracks outstanding reads so that `user_req_dataout` is steered to the client that issued the read, with a per-client valid strobe.

## Interface
Parameters:
- `READ_LATENCY`, default 4: cycles from a read's `USER_REQ_ACK` to valid `USER_REQ_DATAOUT`. Legal range is 1..15.

Ports:
- `CLK` in 1: single clock, same clock as the controller's `CLK_n` domain.
- `RST` in 1: reset, asynchronous, active-high.
- `A_REQ` in 1: client A request, held until `A_ACK`.
- `A_WE` in 1: 1 = write, 0 = read.
- `A_WE_ARRAY` in 4: byte write enables.
- `A_ADDRESS` in 26: word address.
- `A_DATAIN` in 32: write data.
- `A_ACK` out 1: request accepted (combinational).
- `A_DATA_VALID` out 1: read data for A is present this cycle.
- `A_DATAOUT` out 32: read data.
- `B_*`: identical set for client B.
- `USER_REQ` out 1, `USER_REQ_WE` out 1, `USER_REQ_WE_ARRAY` out 4, `USER_REQ_ADDRESS` out 26, `USER_REQ_DATAIN` out 32: request to the controller. All are registered.
- `USER_REQ_ACK` in 1: controller accept.
- `USER_REQ_DATAOUT` in 32: controller read data.

## Operation
State machine, two states:
- **IDLE**
  - No request pending: stay in IDLE.
  - Otherwise choose a winner:
    - Only one client requesting: that client wins.
    - Both requesting: the client not equal to `last_grant` wins.
  - Latch the winner's WE, WE_ARRAY, ADDRESS and DATAIN into the `USER_REQ_*` registers.
  - Set `USER_REQ` = 1, set `owner` = winner, go to ISSUE.
- **ISSUE**
  - Hold `USER_REQ` and all `USER_REQ_*` fields stable.
  - When `USER_REQ_ACK` = 1:
    - `X_ACK` = 1 for `owner`, same cycle.
    - `last_grant` <= `owner`.
    - `USER_REQ` <= 0; go to IDLE.
    - If the request is a read, push {valid=1, tag=`owner`} into the read tag pipe.

Rules:
- `USER_REQ_ACK` while in IDLE is ignored.
- A client's request fields are sampled only in IDLE. Changes while in ISSUE have no effect.
- Read tag pipe: `READ_LATENCY` stages of {valid, tag}, shifting every cycle. Stage 0 is loaded on a read ack and is 0 otherwise.
- Output stage (index `READ_LATENCY`-1): `A_DATA_VALID` = valid & tag==A; `B_DATA_VALID` = valid & tag==B.
- `A_DATAOUT` and `B_DATAOUT` both equal `USER_REQ_DATAOUT` combinationally. Clients qualify it with their own valid.
- Writes never produce a valid strobe.
- Reset values:
  - State IDLE, `USER_REQ` 0, all `USER_REQ_*` fields 0.
  - `owner` A, `last_grant` B, so A wins the first tie.
  - Tag pipe all invalid; `A_ACK`/`B_ACK`/`*_DATA_VALID` all 0.
- Reset mid-operation: the pending request is dropped and `USER_REQ` falls asynchronously. In-flight reads are discarded, with no valid strobe after reset.

## Timing
- Request high at cycle 0, state IDLE → `USER_REQ` high from cycle 1.
- Ack sampled in cycle k → `X_ACK` high in cycle k only. State is IDLE in k+1. The next `USER_REQ` rises at k+2 at the earliest, so there is one bubble per transaction.
- Clients deassert `X_REQ` at the edge ending cycle k. A request still high in cycle k+1 is treated as a new request.
- Read acked in cycle k → `X_DATA_VALID` high in cycle k+`READ_LATENCY`, for exactly one cycle.
- Back-to-back reads produce back-to-back valids in issue order. The tag pipe holds at most `READ_LATENCY` entries and cannot overflow.
- Ack and a pipe output in the same cycle are independent. Both happen.

## Structure
- Package `mcu_arb_pkg`:
  - `ADDR_W`=26, `DATA_W`=32, `MASK_W`=4.
  - Owner encoding `OWNER_A`=0, `OWNER_B`=1.
  - State encoding `ST_IDLE`, `ST_ISSUE`.
- Sub-module `read_tag_pipe`: parameterised shift register of {valid, tag}, ports CLK, RST, push, push_tag, out_valid, out_tag.
- The arbiter FSM and request registers stay in the top module.

## Test plan
- A reads 0x0000123, B idle, controller acks 3 cycles after `USER_REQ` → `USER_REQ_ADDRESS`=0x0000123, `USER_REQ_WE`=0. `A_ACK` high in the ack cycle. `A_DATA_VALID` 4 cycles later with `A_DATAOUT`=0xDEADBEEF. `B_DATA_VALID` stays 0.
- A and B both request continuously after reset, immediate acks → grants alternate A, B, A, B. `USER_REQ` shows one bubble cycle between grants.
- B writes 0x1FFFFFF with WE_ARRAY=4'b0101 and data 0xCAFEF00D → fields appear unchanged on `USER_REQ_*`. `B_ACK` pulses on ack. No valid strobe ever follows.
- Alternating A read and B read acked on consecutive opportunities, `READ_LATENCY`=4 → valids arrive A then B at ack+4 each, each routed to the correct client.
- `RST` asserted while in ISSUE and with two reads in the tag pipe → `USER_REQ` drops immediately and no `*_DATA_VALID` follows. After release, A wins the first tie.
- `USER_REQ_ACK` pulsed while in IDLE with no requests → no state change, no `X_ACK`, tag pipe stays empty.
